// File: rtl/win_tracker.sv
// Per-user and all-user best-score tracker with win LEDs held for HOLD_TICKS ms.
// Each round runs COMPARE then UPDATE; a win enters SHOW until the hold expires or a new round starts.
module win_tracker #(
   parameter int NUM_USERS  = 4,
   parameter int SCORE_W    = 5,
   parameter int HOLD_TICKS = 2000,
   localparam int ID_W      = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1,
   localparam int CNT_W     = $clog2(HOLD_TICKS + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               round_done,
   input  logic [SCORE_W-1:0] round_score,
   input  logic [ID_W-1:0]    user_id,
   input  logic               logged_in,
   input  logic               tick_1ms,
   output logic               personal_win,
   output logic               global_win,
   output logic [SCORE_W-1:0] user_best,
   output logic [SCORE_W-1:0] global_best,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, COMPARE, UPDATE, SHOW} state_e;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);

   state_e             state_q, state_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic               p_hit_q, p_hit_d;
   logic               g_hit_q, g_hit_d;
   logic               pw_q, pw_d;
   logic               gw_q, gw_d;
   logic [SCORE_W-1:0] user_best_q, user_best_d;
   logic [SCORE_W-1:0] global_best_q, global_best_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               tbl_we;
   logic [SCORE_W-1:0] tbl_rd;
   logic               capture;

   logic [SCORE_W-1:0] best_q [NUM_USERS];

   assign tbl_rd  = best_q[id_q];
   assign capture = round_done & logged_in;

   always_comb begin
      state_d       = state_q;
      score_d       = score_q;
      id_d          = id_q;
      p_hit_d       = p_hit_q;
      g_hit_d       = g_hit_q;
      pw_d          = pw_q;
      gw_d          = gw_q;
      user_best_d   = user_best_q;
      global_best_d = global_best_q;
      cnt_d         = cnt_q;
      tbl_we        = 1'b0;
      case (state_q)
         IDLE: begin
            if (capture) begin
               score_d = round_score;
               id_d    = user_id;
               state_d = COMPARE;
            end
         end
         COMPARE: begin
            p_hit_d = score_q > tbl_rd;
            g_hit_d = score_q > global_best_q;
            state_d = UPDATE;
         end
         UPDATE: begin
            tbl_we      = p_hit_q;
            user_best_d = p_hit_q ? score_q : tbl_rd;
            if (g_hit_q) global_best_d = score_q;
            pw_d    = p_hit_q;
            gw_d    = g_hit_q;
            cnt_d   = '0;
            state_d = (p_hit_q || g_hit_q) ? SHOW : IDLE;
         end
         SHOW: begin
            // A new round pre-empts the display and restarts the hold window.
            if (capture) begin
               pw_d    = 1'b0;
               gw_d    = 1'b0;
               cnt_d   = '0;
               score_d = round_score;
               id_d    = user_id;
               state_d = COMPARE;
            end else if (tick_1ms) begin
               if (cnt_q >= HOLD_LAST) begin
                  pw_d    = 1'b0;
                  gw_d    = 1'b0;
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         score_q       <= '0;
         id_q          <= '0;
         p_hit_q       <= 1'b0;
         g_hit_q       <= 1'b0;
         pw_q          <= 1'b0;
         gw_q          <= 1'b0;
         user_best_q   <= '0;
         global_best_q <= '0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         score_q       <= score_d;
         id_q          <= id_d;
         p_hit_q       <= p_hit_d;
         g_hit_q       <= g_hit_d;
         pw_q          <= pw_d;
         gw_q          <= gw_d;
         user_best_q   <= user_best_d;
         global_best_q <= global_best_d;
         cnt_q         <= cnt_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_USERS; gi++) begin : g_tbl
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               best_q[gi] <= '0;
            else if (tbl_we && (id_q == ID_W'(gi)))
               best_q[gi] <= score_q;
         end
      end
   endgenerate

   assign personal_win = pw_q;
   assign global_win   = gw_q;
   assign user_best    = user_best_q;
   assign global_best  = global_best_q;
   assign busy         = (state_q == COMPARE) || (state_q == UPDATE);

endmodule

// File: tb/tb_win_tracker.sv
// Bench for win_tracker: directed vector table, multi-cycle corner sequences,
// and random rounds checked against a simple score-table model.
module tb_win_tracker;

   localparam int HOLD = 2000;

   logic       clk;
   logic       rst;
   logic       round_done;
   logic [4:0] round_score;
   logic [1:0] user_id;
   logic       logged_in;
   logic       tick_1ms;
   logic       personal_win;
   logic       global_win;
   logic [4:0] user_best;
   logic [4:0] global_best;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   int m_best[4];
   int m_gb, m_ub, m_cnt;
   bit m_pw, m_gw;

   typedef struct {
      int id;
      int score;
      bit logged;
      bit pw;
      bit gw;
      int ub;
      int gb;
   } vec_t;

   vec_t vecs[9];

   win_tracker #(.NUM_USERS(4), .SCORE_W(5), .HOLD_TICKS(HOLD)) dut (
      .clk          (clk),
      .rst          (rst),
      .round_done   (round_done),
      .round_score  (round_score),
      .user_id      (user_id),
      .logged_in    (logged_in),
      .tick_1ms     (tick_1ms),
      .personal_win (personal_win),
      .global_win   (global_win),
      .user_best    (user_best),
      .global_best  (global_best),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulses round_done for one edge; returns 1 ns after the sampling edge.
   task automatic round(input int id, input int sc, input bit li);
      round_done  = 1'b1;
      user_id     = id[1:0];
      round_score = sc[4:0];
      logged_in   = li;
      step();
      round_done  = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick_1ms = 1'b1;
         step();
         tick_1ms = 1'b0;
      end
   endtask

   task automatic do_reset();
      #2 rst = 1'b0;
      #4 rst = 1'b1;
      step();
      for (int i = 0; i < 4; i++) m_best[i] = 0;
      m_gb = 0; m_ub = 0; m_cnt = 0; m_pw = 0; m_gw = 0;
   endtask

   task automatic model_round(input int id, input int sc, input bit li);
      bit p, g;
      if (li) begin
         p = sc > m_best[id];
         g = sc > m_gb;
         if (p) m_best[id] = sc;
         if (g) m_gb = sc;
         m_ub  = m_best[id];
         m_pw  = p;
         m_gw  = g;
         m_cnt = 0;
      end
   endtask

   task automatic model_tick();
      if (m_pw || m_gw) begin
         m_cnt++;
         if (m_cnt == HOLD) begin
            m_pw = 0; m_gw = 0; m_cnt = 0;
         end
      end
   endtask

   initial begin
      rst = 1'b0; round_done = 1'b0; round_score = '0; user_id = '0;
      logged_in = 1'b0; tick_1ms = 1'b0;

      vecs[0] = '{1,  7, 1, 1, 1,  7,  7};
      vecs[1] = '{2,  5, 1, 1, 0,  5,  7};
      vecs[2] = '{2,  5, 1, 0, 0,  5,  7};
      vecs[3] = '{1, 20, 0, 0, 0,  5,  7};
      vecs[4] = '{0,  0, 1, 0, 0,  0,  7};
      vecs[5] = '{3, 31, 1, 1, 1, 31, 31};
      vecs[6] = '{3, 31, 1, 0, 0, 31, 31};
      vecs[7] = '{1,  9, 1, 1, 0,  9, 31};
      vecs[8] = '{1,  8, 1, 0, 0,  9, 31};

      #3;
      check("reset_pw",   personal_win, 0);
      check("reset_gw",   global_win,   0);
      check("reset_ub",   user_best,    0);
      check("reset_gb",   global_best,  0);
      check("reset_busy", busy,         0);
      #3 rst = 1'b1;
      step();

      // Directed vector table
      for (int i = 0; i < 9; i++) begin
         round(vecs[i].id, vecs[i].score, vecs[i].logged);
         check($sformatf("vec%0d_busy", i), busy, vecs[i].logged);
         step();
         step();
         $display("vec%0d id=%0d score=%0d logged=%0d -> pw=%0d gw=%0d ub=%0d gb=%0d busy=%0d",
                  i, vecs[i].id, vecs[i].score, vecs[i].logged,
                  personal_win, global_win, user_best, global_best, busy);
         check($sformatf("vec%0d_pw", i), personal_win, vecs[i].pw);
         check($sformatf("vec%0d_gw", i), global_win,   vecs[i].gw);
         check($sformatf("vec%0d_ub", i), user_best,    vecs[i].ub);
         check($sformatf("vec%0d_gb", i), global_best,  vecs[i].gb);
         check($sformatf("vec%0d_idle", i), busy, 0);
      end

      // Hold window: LEDs stay lit through 1999 ticks, clear on the 2000th
      do_reset();
      round(1, 7, 1);
      step(); step();
      check("hold_pw_set", personal_win, 1);
      check("hold_gw_set", global_win,   1);
      ticks(HOLD - 1);
      check("hold_pw_1999", personal_win, 1);
      check("hold_gw_1999", global_win,   1);
      ticks(1);
      $display("hold expiry -> pw=%0d gw=%0d", personal_win, global_win);
      check("hold_pw_2000", personal_win, 0);
      check("hold_gw_2000", global_win,   0);
      check("hold_gb",      global_best,  7);

      // Pre-emption of SHOW by a new round restarts the hold counter
      round(1, 9, 1);
      step(); step();
      check("pre_first_pw", personal_win, 1);
      check("pre_first_gw", global_win,   1);
      ticks(500);
      round(3, 12, 1);
      check("pre_drop0_pw", personal_win, 0);
      check("pre_drop0_gw", global_win,   0);
      step();
      check("pre_drop1_pw", personal_win, 0);
      step();
      $display("preempt id=3 score=12 -> pw=%0d gw=%0d ub=%0d gb=%0d",
               personal_win, global_win, user_best, global_best);
      check("pre_new_pw", personal_win, 1);
      check("pre_new_gw", global_win,   1);
      check("pre_new_ub", user_best,    12);
      ticks(HOLD - 1);
      check("pre_hold_1999", personal_win, 1);
      ticks(1);
      check("pre_hold_2000", personal_win, 0);

      // Asynchronous reset during SHOW
      round(2, 4, 1);
      step(); step();
      check("ar_show_pw", personal_win, 1);
      #2 rst = 1'b0;
      #1;
      check("ar_pw",   personal_win, 0);
      check("ar_busy", busy,         0);
      check("ar_gb",   global_best,  0);
      check("ar_ub",   user_best,    0);
      #2 rst = 1'b1;
      step();

      // Reset during UPDATE discards the pending write
      round(2, 6, 1);
      step();
      check("au_busy_before", busy, 1);
      #2 rst = 1'b0;
      #1;
      check("au_busy_after", busy, 0);
      #2 rst = 1'b1;
      step();
      round(1, 1, 1);
      step(); step();
      $display("post-reset id=1 score=1 -> pw=%0d gw=%0d gb=%0d",
               personal_win, global_win, global_best);
      check("au_pw", personal_win, 1);
      check("au_gw", global_win,   1);
      check("au_gb", global_best,  1);

      // Maximum score, then a tie at the maximum
      round(0, 31, 1);
      step(); step();
      check("max_pw", personal_win, 1);
      check("max_gw", global_win,   1);
      check("max_gb", global_best,  31);
      round(0, 31, 1);
      step(); step();
      check("maxtie_pw", personal_win, 0);
      check("maxtie_gw", global_win,   0);
      check("maxtie_ub", user_best,    31);

      // Random rounds against the model
      do_reset();
      for (int r = 0; r < 150; r++) begin
         int id, sc, nt;
         bit li;
         id = $urandom_range(0, 3);
         sc = $urandom_range(0, 31);
         li = ($urandom_range(0, 7) != 0);
         round(id, sc, li);
         step(); step();
         model_round(id, sc, li);
         $display("rnd%0d id=%0d score=%0d logged=%0d -> pw=%0d gw=%0d ub=%0d gb=%0d",
                  r, id, sc, li, personal_win, global_win, user_best, global_best);
         check("rnd_pw", personal_win, m_pw);
         check("rnd_gw", global_win,   m_gw);
         check("rnd_ub", user_best,    m_ub);
         check("rnd_gb", global_best,  m_gb);
         nt = $urandom_range(0, 3);
         ticks(nt);
         for (int k = 0; k < nt; k++) model_tick();
         check("rnd_tick_pw", personal_win, m_pw);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
